// File: rtl/beat_grid_timer.sv
// beat_grid_timer: runtime-programmable tick/beat/bar pulse grid with pause,
// synchronous restart, position indices, bar counter and a one-deep config slot.
module beat_grid_timer #(
    parameter int unsigned DIV                 = 4,
    parameter int unsigned CNT_W               = 32,
    parameter int unsigned BEAT_W              = 4,
    parameter int unsigned BAR_W               = 16,
    parameter int unsigned DEFAULT_TICK_CYCLES = 6_400_000,
    parameter int unsigned DEFAULT_BPB         = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    restart_i,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [CNT_W-1:0]        tick_cycles_i,
    input  logic [BEAT_W-1:0]       beats_per_bar_i,
    output logic                    tick_o,
    output logic                    beat_o,
    output logic                    bar_o,
    output logic [$clog2(DIV)-1:0]  tick_idx_o,
    output logic [BEAT_W-1:0]       beat_idx_o,
    output logic [BAR_W-1:0]        bar_cnt_o
);

    localparam int unsigned TIDX_W = $clog2(DIV);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [BEAT_W-1:0] bpb_q, bpb_d;
    logic [TIDX_W-1:0] pt_q, pt_d;
    logic [BEAT_W-1:0] pb_q, pb_d;
    logic [CNT_W-1:0]  pend_period_q, pend_period_d;
    logic [BEAT_W-1:0] pend_bpb_q, pend_bpb_d;
    logic              ready_d;
    logic              tick_d, beat_d, bar_d;
    logic [TIDX_W-1:0] tidx_d;
    logic [BEAT_W-1:0] bidx_d;
    logic [BAR_W-1:0]  bar_cnt_d;

    logic              xfer;
    logic              last_cnt;
    logic              bar_end;
    logic [CNT_W-1:0]  clamp_period;
    logic [BEAT_W-1:0] clamp_bpb;

    // Handshake, end-of-period and end-of-bar decodes plus capture clamping.
    always_comb begin
        xfer         = cfg_valid_i && cfg_ready_o;
        last_cnt     = (cnt_q == period_q - CNT_W'(1));
        bar_end      = (pt_q == TIDX_W'(DIV - 1)) && (pb_q == bpb_q - BEAT_W'(1));
        clamp_period = (tick_cycles_i < CNT_W'(2)) ? CNT_W'(2) : tick_cycles_i;
        clamp_bpb    = (beats_per_bar_i == '0) ? BEAT_W'(1) : beats_per_bar_i;
    end

    // Next-state: restart beats tick/apply; a pending config lands at the bar
    // boundary while running, or at once while paused.
    always_comb begin
        cnt_d         = cnt_q;
        period_d      = period_q;
        bpb_d         = bpb_q;
        pt_d          = pt_q;
        pb_d          = pb_q;
        pend_period_d = pend_period_q;
        pend_bpb_d    = pend_bpb_q;
        ready_d       = cfg_ready_o;
        tick_d        = 1'b0;
        beat_d        = 1'b0;
        bar_d         = 1'b0;
        tidx_d        = tick_idx_o;
        bidx_d        = beat_idx_o;
        bar_cnt_d     = bar_cnt_o;

        if (restart_i) begin
            cnt_d     = '0;
            pt_d      = '0;
            pb_d      = '0;
            bar_cnt_d = '0;
            if (!cfg_ready_o) begin
                period_d = pend_period_q;
                bpb_d    = pend_bpb_q;
                ready_d  = 1'b1;
            end
        end else if (enable_i) begin
            if (last_cnt) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                tidx_d = pt_q;
                bidx_d = pb_q;
                beat_d = (pt_q == '0);
                bar_d  = (pt_q == '0) && (pb_q == '0);
                if (bar_d) begin
                    bar_cnt_d = bar_cnt_o + BAR_W'(1);
                end
                if (pt_q == TIDX_W'(DIV - 1)) begin
                    pt_d = '0;
                    pb_d = (pb_q >= bpb_q - BEAT_W'(1)) ? '0 : pb_q + BEAT_W'(1);
                end else begin
                    pt_d = pt_q + TIDX_W'(1);
                end
                if (!cfg_ready_o && bar_end) begin
                    period_d = pend_period_q;
                    bpb_d    = pend_bpb_q;
                    ready_d  = 1'b1;
                    pt_d     = '0;
                    pb_d     = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!cfg_ready_o) begin
            period_d = pend_period_q;
            bpb_d    = pend_bpb_q;
            ready_d  = 1'b1;
            cnt_d    = '0;
            pt_d     = '0;
            pb_d     = '0;
        end

        if (xfer) begin
            pend_period_d = clamp_period;
            pend_bpb_d    = clamp_bpb;
            ready_d       = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            period_q      <= CNT_W'(DEFAULT_TICK_CYCLES);
            bpb_q         <= BEAT_W'(DEFAULT_BPB);
            pt_q          <= '0;
            pb_q          <= '0;
            pend_period_q <= '0;
            pend_bpb_q    <= '0;
            cfg_ready_o   <= 1'b1;
            tick_o        <= 1'b0;
            beat_o        <= 1'b0;
            bar_o         <= 1'b0;
            tick_idx_o    <= '0;
            beat_idx_o    <= '0;
            bar_cnt_o     <= '0;
        end else begin
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            bpb_q         <= bpb_d;
            pt_q          <= pt_d;
            pb_q          <= pb_d;
            pend_period_q <= pend_period_d;
            pend_bpb_q    <= pend_bpb_d;
            cfg_ready_o   <= ready_d;
            tick_o        <= tick_d;
            beat_o        <= beat_d;
            bar_o         <= bar_d;
            tick_idx_o    <= tidx_d;
            beat_idx_o    <= bidx_d;
            bar_cnt_o     <= bar_cnt_d;
        end
    end

endmodule

// File: tb/tb_beat_grid_timer.sv
// Directed, table-driven bench for beat_grid_timer (DIV=4, small default period).
module tb_beat_grid_timer;

    localparam int unsigned DIV    = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BEAT_W = 4;
    localparam int unsigned BAR_W  = 16;

    typedef struct {
        int          cyc;
        logic        tick;
        logic        beat;
        logic        bar;
        logic [1:0]  tidx;
        logic [3:0]  bidx;
        logic [15:0] bcnt;
        logic        rdy;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              enable_i = 1'b0;
    logic              restart_i = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [CNT_W-1:0]  tick_cycles_i = '0;
    logic [BEAT_W-1:0] beats_per_bar_i = '0;
    logic              tick_o, beat_o, bar_o;
    logic [1:0]        tick_idx_o;
    logic [BEAT_W-1:0] beat_idx_o;
    logic [BAR_W-1:0]  bar_cnt_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    vec_t tbl[$];

    beat_grid_timer #(
        .DIV(DIV), .CNT_W(CNT_W), .BEAT_W(BEAT_W), .BAR_W(BAR_W),
        .DEFAULT_TICK_CYCLES(7), .DEFAULT_BPB(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .restart_i(restart_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .tick_cycles_i(tick_cycles_i), .beats_per_bar_i(beats_per_bar_i),
        .tick_o(tick_o), .beat_o(beat_o), .bar_o(bar_o),
        .tick_idx_o(tick_idx_o), .beat_idx_o(beat_idx_o), .bar_cnt_o(bar_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int c, logic t, logic be, logic ba, int ti, int bi, int bc, logic r);
        vec_t v;
        v.cyc = c; v.tick = t; v.beat = be; v.bar = ba;
        v.tidx = 2'(ti); v.bidx = 4'(bi); v.bcnt = 16'(bc); v.rdy = r;
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) step();
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_vec(string name, vec_t v);
        logic [25:0] act, exp;
        act = {tick_o, beat_o, bar_o, tick_idx_o, beat_idx_o, bar_cnt_o, cfg_ready_o};
        exp = {v.tick, v.beat, v.bar, v.tidx, v.bidx, v.bcnt, v.rdy};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got tick=%b beat=%b bar=%b tidx=%0d bidx=%0d bcnt=%0d rdy=%b want tick=%b beat=%b bar=%b tidx=%0d bidx=%0d bcnt=%0d rdy=%b",
                     name, cyc, tick_o, beat_o, bar_o, tick_idx_o, beat_idx_o, bar_cnt_o, cfg_ready_o,
                     v.tick, v.beat, v.bar, v.tidx, v.bidx, v.bcnt, v.rdy);
        end
    endtask

    // Steps to cycle 'last', checking table rows as their cycle comes up; a
    // nonzero 'per' also checks that tick_o is high exactly on multiples of per.
    task automatic run_table(string name, int last, int per);
        int idx = 0;
        int grid_err = 0;
        while (cyc < last) begin
            step();
            if (per != 0 && tick_o !== ((cyc % per) == 0)) grid_err++;
            if (idx < tbl.size() && tbl[idx].cyc == cyc) begin
                check_vec(name, tbl[idx]);
                idx++;
            end
        end
        check({name, "_rows_reached"}, idx, tbl.size());
        if (per != 0) check({name, "_tick_grid_errs"}, grid_err, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        enable_i = 1'b0;
        restart_i = 1'b0;
        cfg_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Reset, load a config while paused, then start running with cycle 0 = now.
    task automatic init_run(int t, int bpb);
        do_reset();
        cfg_valid_i = 1'b1;
        tick_cycles_i = CNT_W'(t);
        beats_per_bar_i = BEAT_W'(bpb);
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        @(posedge clk_i); #1;
        enable_i = 1'b1;
        cyc = 0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check_vec("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 1));

        // A: T=5, bpb=4 steady grid
        init_run(5, 4);
        tbl.delete();
        tbl.push_back(mk(4,   0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(5,   1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(6,   0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(10,  1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(20,  1, 0, 0, 3, 0, 1, 1));
        tbl.push_back(mk(25,  1, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(45,  1, 1, 0, 0, 2, 1, 1));
        tbl.push_back(mk(80,  1, 0, 0, 3, 3, 1, 1));
        tbl.push_back(mk(84,  0, 0, 0, 3, 3, 1, 1));
        tbl.push_back(mk(85,  1, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(165, 1, 1, 1, 0, 0, 3, 1));
        tbl.push_back(mk(166, 0, 0, 0, 0, 0, 3, 1));
        run_table("A_grid", 170, 5);

        // B: config T=3 offered at cycle 30, applied at the bar boundary
        init_run(5, 4);
        run_to(30);
        cfg_valid_i = 1'b1;
        tick_cycles_i = CNT_W'(3);
        beats_per_bar_i = BEAT_W'(4);
        step();
        cfg_valid_i = 1'b0;
        check_vec("B_ready_drop", mk(31, 0, 0, 0, 1, 1, 1, 0));
        tbl.delete();
        tbl.push_back(mk(50, 1, 0, 0, 1, 2, 1, 0));
        tbl.push_back(mk(79, 0, 0, 0, 2, 3, 1, 0));
        tbl.push_back(mk(80, 1, 0, 0, 3, 3, 1, 1));
        tbl.push_back(mk(82, 0, 0, 0, 3, 3, 1, 1));
        tbl.push_back(mk(83, 1, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(86, 1, 0, 0, 1, 0, 2, 1));
        tbl.push_back(mk(89, 1, 0, 0, 2, 0, 2, 1));
        tbl.push_back(mk(95, 1, 1, 0, 0, 1, 2, 1));
        run_table("B_cfg_apply", 96, 0);

        // C: pause for cycles 12..18, tick due at 15 moves to 22
        init_run(5, 4);
        run_to(12);
        enable_i = 1'b0;
        tbl.delete();
        tbl.push_back(mk(15, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(18, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(19, 0, 0, 0, 1, 0, 1, 1));
        run_table("C_paused", 19, 0);
        enable_i = 1'b1;
        tbl.delete();
        tbl.push_back(mk(20, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(21, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(22, 1, 0, 0, 2, 0, 1, 1));
        tbl.push_back(mk(26, 0, 0, 0, 2, 0, 1, 1));
        tbl.push_back(mk(27, 1, 0, 0, 3, 0, 1, 1));
        tbl.push_back(mk(32, 1, 1, 0, 0, 1, 1, 1));
        run_table("C_resume", 33, 0);

        // D: restart on the cycle where cnt==T-1
        init_run(5, 4);
        run_to(14);
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        check_vec("D_restart_no_tick", mk(15, 0, 0, 0, 1, 0, 0, 1));
        tbl.delete();
        tbl.push_back(mk(19, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(20, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(21, 0, 0, 0, 0, 0, 1, 1));
        run_table("D_after_restart", 21, 0);

        // E: clamped config while paused -> T=2, bpb=1
        do_reset();
        cfg_valid_i = 1'b1;
        tick_cycles_i = '0;
        beats_per_bar_i = '0;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
        check("E_ready_low", int'(cfg_ready_o), 0);
        @(posedge clk_i); #1;
        check("E_ready_back", int'(cfg_ready_o), 1);
        enable_i = 1'b1;
        cyc = 0;
        tbl.delete();
        tbl.push_back(mk(1,  0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(2,  1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(4,  1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(8,  1, 0, 0, 3, 0, 1, 1));
        tbl.push_back(mk(10, 1, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(18, 1, 1, 1, 0, 0, 3, 1));
        run_table("E_clamped", 20, 2);

        // F: async reset with a pending config, then default T=7, bpb=4
        init_run(5, 4);
        run_to(7);
        cfg_valid_i = 1'b1;
        tick_cycles_i = CNT_W'(3);
        beats_per_bar_i = BEAT_W'(2);
        step();
        cfg_valid_i = 1'b0;
        check("F_ready_low", int'(cfg_ready_o), 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_vec("F_async_reset", mk(8, 0, 0, 0, 0, 0, 0, 1));
        rst_ni = 1'b1;
        cyc = 0;
        tbl.delete();
        tbl.push_back(mk(3,   0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(6,   0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(7,   1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(14,  1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(119, 1, 1, 1, 0, 0, 2, 1));
        tbl.push_back(mk(120, 0, 0, 0, 0, 0, 2, 1));
        run_table("F_defaults", 125, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
